// File: rtl/cdb_arbiter_if.sv
// Producer-to-arbiter result handshakes and the registered CDB broadcast bundle.
// The slave modport is the arbiter side; the master modport is the producer/consumer side.
interface cdb_arbiter_if #(
    parameter int unsigned IDX_W = 6
);
    logic             alu_valid;
    logic [IDX_W-1:0] alu_rob_index;
    logic [31:0]      alu_res;
    logic             alu_jump;
    logic [31:0]      alu_jump_pc;
    logic             alu_ready;

    logic             lsb_valid;
    logic [IDX_W-1:0] lsb_rob_index;
    logic [31:0]      lsb_res;
    logic             lsb_ready;

    logic             cdb_valid;
    logic             cdb_src;
    logic [IDX_W-1:0] cdb_rob_index;
    logic [31:0]      cdb_res;
    logic             cdb_jump;
    logic [31:0]      cdb_jump_pc;

    modport master (
        output alu_valid, alu_rob_index, alu_res, alu_jump, alu_jump_pc,
        output lsb_valid, lsb_rob_index, lsb_res,
        input  alu_ready, lsb_ready,
        input  cdb_valid, cdb_src, cdb_rob_index, cdb_res, cdb_jump, cdb_jump_pc
    );

    modport slave (
        input  alu_valid, alu_rob_index, alu_res, alu_jump, alu_jump_pc,
        input  lsb_valid, lsb_rob_index, lsb_res,
        output alu_ready, lsb_ready,
        output cdb_valid, cdb_src, cdb_rob_index, cdb_res, cdb_jump, cdb_jump_pc
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two per-source result FIFOs (ALU, LSB) drained one
// entry per enabled cycle onto a registered CDB, round-robin between sources.
module cdb_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         flush,
    cdb_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [0:0] SRC_ALU = 1'b0;
    localparam logic [0:0] SRC_LSB = 1'b1;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [31:0]      res;
        logic             jump;
        logic [31:0]      pc;
    } alu_ent_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [31:0]      res;
    } lsb_ent_t;

    alu_ent_t         alu_mem [DEPTH];
    lsb_ent_t         lsb_mem [DEPTH];
    logic [PTR_W-1:0] alu_head, alu_tail, lsb_head, lsb_tail;
    logic [CNT_W-1:0] alu_count, lsb_count;
    logic [0:0]       last_grant;

    logic alu_ready_c, lsb_ready_c;
    logic alu_push_c, lsb_push_c, alu_pop_c, lsb_pop_c;

    // Ready depends only on registered counts, so a same-edge pop never frees a slot early.
    always_comb begin
        alu_ready_c = (alu_count < CNT_W'(DEPTH));
        lsb_ready_c = (lsb_count < CNT_W'(DEPTH));
        alu_push_c  = bus.alu_valid && alu_ready_c;
        lsb_push_c  = bus.lsb_valid && lsb_ready_c;
        alu_pop_c   = (alu_count != '0) && ((lsb_count == '0) || (last_grant == SRC_LSB));
        lsb_pop_c   = (lsb_count != '0) && !alu_pop_c;
    end

    assign bus.alu_ready = alu_ready_c;
    assign bus.lsb_ready = lsb_ready_c;

    // Entry storage; contents need no reset since counts gate every read.
    always_ff @(posedge clk) begin
        if (!rst && rdy && !flush) begin
            if (alu_push_c) begin
                alu_mem[alu_tail] <= '{bus.alu_rob_index, bus.alu_res, bus.alu_jump, bus.alu_jump_pc};
            end
            if (lsb_push_c) begin
                lsb_mem[lsb_tail] <= '{bus.lsb_rob_index, bus.lsb_res};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_head          <= '0;
            alu_tail          <= '0;
            alu_count         <= '0;
            lsb_head          <= '0;
            lsb_tail          <= '0;
            lsb_count         <= '0;
            last_grant        <= SRC_LSB;
            bus.cdb_valid     <= 1'b0;
            bus.cdb_src       <= 1'b0;
            bus.cdb_rob_index <= '0;
            bus.cdb_res       <= '0;
            bus.cdb_jump      <= 1'b0;
            bus.cdb_jump_pc   <= '0;
        end else if (rdy) begin
            if (flush) begin
                alu_head      <= '0;
                alu_tail      <= '0;
                alu_count     <= '0;
                lsb_head      <= '0;
                lsb_tail      <= '0;
                lsb_count     <= '0;
                last_grant    <= SRC_LSB;
                bus.cdb_valid <= 1'b0;
            end else begin
                if (alu_push_c) alu_tail <= alu_tail + PTR_W'(1);
                if (alu_pop_c)  alu_head <= alu_head + PTR_W'(1);
                if (lsb_push_c) lsb_tail <= lsb_tail + PTR_W'(1);
                if (lsb_pop_c)  lsb_head <= lsb_head + PTR_W'(1);
                alu_count <= alu_count + CNT_W'(alu_push_c) - CNT_W'(alu_pop_c);
                lsb_count <= lsb_count + CNT_W'(lsb_push_c) - CNT_W'(lsb_pop_c);

                if (alu_pop_c) begin
                    bus.cdb_valid     <= 1'b1;
                    bus.cdb_src       <= SRC_ALU;
                    bus.cdb_rob_index <= alu_mem[alu_head].idx;
                    bus.cdb_res       <= alu_mem[alu_head].res;
                    bus.cdb_jump      <= alu_mem[alu_head].jump;
                    bus.cdb_jump_pc   <= alu_mem[alu_head].pc;
                    last_grant        <= SRC_ALU;
                end else if (lsb_pop_c) begin
                    bus.cdb_valid     <= 1'b1;
                    bus.cdb_src       <= SRC_LSB;
                    bus.cdb_rob_index <= lsb_mem[lsb_head].idx;
                    bus.cdb_res       <= lsb_mem[lsb_head].res;
                    bus.cdb_jump      <= 1'b0;
                    bus.cdb_jump_pc   <= '0;
                    last_grant        <= SRC_LSB;
                end else begin
                    // Idle bus: only valid drops, payload holds its last value.
                    bus.cdb_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a queue-based reference model checked every edge.
module tb_cdb_arbiter;
    localparam int unsigned IDX_W = 6;

    logic clk = 1'b0;
    logic rst, rdy, flush;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.IDX_W(IDX_W)) bus ();

    cdb_arbiter #(.DEPTH(4), .IDX_W(IDX_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .rdy  (rdy),
        .flush(flush),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [31:0]      res;
        logic             jump;
        logic [31:0]      pc;
    } ent_t;

    ent_t aq[$];
    ent_t lq[$];
    logic lg;
    logic exp_v, exp_s, exp_j;
    logic [IDX_W-1:0] exp_i;
    logic [31:0] exp_r, exp_p;
    logic armed;
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [IDX_W-1:0] ai, input logic [31:0] ar,
                         input logic aj, input logic [31:0] apc,
                         input logic lv, input logic [IDX_W-1:0] li, input logic [31:0] lr);
        bus.alu_valid     = av;
        bus.alu_rob_index = ai;
        bus.alu_res       = ar;
        bus.alu_jump      = aj;
        bus.alu_jump_pc   = apc;
        bus.lsb_valid     = lv;
        bus.lsb_rob_index = li;
        bus.lsb_res       = lr;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    // Advance one clock: check readies, update the model from current inputs, check the CDB.
    task automatic tick();
        ent_t e;
        logic ra, rl, pa;
        ra = (aq.size() < 4);
        rl = (lq.size() < 4);
        if (armed) begin
            chk("alu_ready", 64'(bus.alu_ready), 64'(ra));
            chk("lsb_ready", 64'(bus.lsb_ready), 64'(rl));
        end
        if (rst) begin
            aq.delete(); lq.delete(); lg = 1'b1;
            exp_v = 1'b0; exp_s = 1'b0; exp_i = '0; exp_r = '0; exp_j = 1'b0; exp_p = '0;
        end else if (rdy) begin
            if (flush) begin
                aq.delete(); lq.delete(); lg = 1'b1; exp_v = 1'b0;
            end else begin
                pa = (aq.size() > 0) && ((lq.size() == 0) || lg);
                if (pa) begin
                    e = aq.pop_front();
                    exp_v = 1'b1; exp_s = 1'b0; exp_i = e.idx; exp_r = e.res;
                    exp_j = e.jump; exp_p = e.pc; lg = 1'b0;
                end else if (lq.size() > 0) begin
                    e = lq.pop_front();
                    exp_v = 1'b1; exp_s = 1'b1; exp_i = e.idx; exp_r = e.res;
                    exp_j = 1'b0; exp_p = '0; lg = 1'b1;
                end else begin
                    exp_v = 1'b0;
                end
                if (bus.alu_valid && ra)
                    aq.push_back('{bus.alu_rob_index, bus.alu_res, bus.alu_jump, bus.alu_jump_pc});
                if (bus.lsb_valid && rl)
                    lq.push_back('{bus.lsb_rob_index, bus.lsb_res, 1'b0, 32'h0});
            end
        end
        @(posedge clk);
        #1;
        chk("cdb_valid", 64'(bus.cdb_valid), 64'(exp_v));
        chk("cdb_src", 64'(bus.cdb_src), 64'(exp_s));
        chk("cdb_rob_index", 64'(bus.cdb_rob_index), 64'(exp_i));
        chk("cdb_res", 64'(bus.cdb_res), 64'(exp_r));
        chk("cdb_jump", 64'(bus.cdb_jump), 64'(exp_j));
        chk("cdb_jump_pc", 64'(bus.cdb_jump_pc), 64'(exp_p));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [IDX_W-1:0] ai, li, held_idx;
        logic saw_full;
        armed = 1'b0;
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; lg = 1'b1;
        idle();
        tick();
        armed = 1'b1;
        tick();
        chk("rst_valid", 64'(bus.cdb_valid), 64'd0);
        chk("rst_res", 64'(bus.cdb_res), 64'd0);
        chk("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
        chk("rst_lsb_ready", 64'(bus.lsb_ready), 64'd1);
        rst = 1'b0;

        // Single ALU push: broadcast one edge after capture, then bus goes idle.
        drive(1'b1, 6'd5, 32'h1234, 1'b1, 32'h80, 1'b0, '0, '0);
        tick();
        chk("t1_no_bypass", 64'(bus.cdb_valid), 64'd0);
        idle();
        tick();
        chk("t1_valid", 64'(bus.cdb_valid), 64'd1);
        chk("t1_src", 64'(bus.cdb_src), 64'd0);
        chk("t1_idx", 64'(bus.cdb_rob_index), 64'd5);
        chk("t1_res", 64'(bus.cdb_res), 64'h1234);
        chk("t1_jump", 64'(bus.cdb_jump), 64'd1);
        chk("t1_pc", 64'(bus.cdb_jump_pc), 64'h80);
        tick();
        chk("t1_idle", 64'(bus.cdb_valid), 64'd0);

        // Simultaneous push from reset: ALU first, then LSB.
        do_reset();
        drive(1'b1, 6'd1, 32'h11, 1'b1, 32'h44, 1'b1, 6'd2, 32'h22);
        tick();
        idle();
        tick();
        chk("t2_first_src", 64'(bus.cdb_src), 64'd0);
        chk("t2_first_idx", 64'(bus.cdb_rob_index), 64'd1);
        tick();
        chk("t2_second_src", 64'(bus.cdb_src), 64'd1);
        chk("t2_second_idx", 64'(bus.cdb_rob_index), 64'd2);
        chk("t2_lsb_jump", 64'(bus.cdb_jump), 64'd0);
        chk("t2_lsb_pc", 64'(bus.cdb_jump_pc), 64'd0);

        // Saturation: both sources push every cycle; indices advance only when accepted.
        do_reset();
        ai = 6'd0; li = 6'd32; saw_full = 1'b0;
        for (int c = 0; c < 24; c++) begin
            drive(1'b1, ai, 32'hA000 + 32'(ai), ai[0], 32'h100 + 32'(ai),
                  1'b1, li, 32'hB000 + 32'(li));
            if (aq.size() < 4) ai = ai + 6'd1;
            if (lq.size() < 4) li = li + 6'd1;
            tick();
            if (!bus.lsb_ready || !bus.alu_ready) saw_full = 1'b1;
        end
        chk("t3_backpressure_seen", 64'(saw_full), 64'd1);
        idle();
        for (int c = 0; c < 10; c++) tick();
        chk("t3_drained", 64'(bus.cdb_valid), 64'd0);

        // Flush mid-fill (ALU 3 deep, LSB 2 deep) together with an ALU push.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 6'(40 + c), 32'(c), 1'b0, '0, (c != 2), 6'(50 + c), 32'(c));
            tick();
        end
        flush = 1'b1;
        drive(1'b1, 6'd60, 32'h60, 1'b0, '0, 1'b0, '0, '0);
        tick();
        flush = 1'b0;
        chk("t4_flush_valid", 64'(bus.cdb_valid), 64'd0);
        chk("t4_alu_ready", 64'(bus.alu_ready), 64'd1);
        chk("t4_lsb_ready", 64'(bus.lsb_ready), 64'd1);
        drive(1'b1, 6'd61, 32'h61, 1'b1, 32'h610, 1'b0, '0, '0);
        tick();
        chk("t4_post_push_idle", 64'(bus.cdb_valid), 64'd0);
        idle();
        tick();
        chk("t4_next_idx", 64'(bus.cdb_rob_index), 64'd61);
        chk("t4_next_valid", 64'(bus.cdb_valid), 64'd1);
        for (int c = 0; c < 3; c++) tick();
        chk("t4_no_stale", 64'(bus.cdb_valid), 64'd0);

        // rdy stall with both FIFOs non-empty and valid inputs present.
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 6'(10 + c), 32'(c), 1'b0, '0, 1'b1, 6'(20 + c), 32'(c));
            tick();
        end
        held_idx = bus.cdb_rob_index;
        rdy = 1'b0;
        drive(1'b1, 6'd30, 32'h30, 1'b0, '0, 1'b1, 6'd31, 32'h31);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t5_hold_idx", 64'(bus.cdb_rob_index), 64'(held_idx));
        end
        rdy = 1'b1;
        idle();
        for (int c = 0; c < 8; c++) tick();

        // Reset mid-operation while the CDB is busy.
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 6'(33 + c), 32'(c), 1'b1, 32'h9, 1'b1, 6'(35 + c), 32'(c));
            tick();
        end
        chk("t6_busy", 64'(bus.cdb_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_valid", 64'(bus.cdb_valid), 64'd0);
        chk("t6_rst_idx", 64'(bus.cdb_rob_index), 64'd0);
        chk("t6_rst_pc", 64'(bus.cdb_jump_pc), 64'd0);
        chk("t6_rst_alu_ready", 64'(bus.alu_ready), 64'd1);
        chk("t6_rst_lsb_ready", 64'(bus.lsb_ready), 64'd1);
        drive(1'b1, 6'd7, 32'h7, 1'b0, '0, 1'b1, 6'd8, 32'h8);
        tick();
        idle();
        tick();
        chk("t6_first_grant_alu", 64'(bus.cdb_src), 64'd0);
        chk("t6_first_grant_idx", 64'(bus.cdb_rob_index), 64'd7);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
